ff_reg_rr_arbiter: RTL
======================

Name: ff_reg_rr_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DATA_WIDTH-bit register bank of positive-edge D flip-flops.
- NUM_REQ requesters compete for write access. The block grants one requester at a time and loads its data into the shared register.
- After each write, the register is held stable for HOLD_CYCLES before the next grant.
- Sits between requester logic and the shared register consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of the shared register.
- HOLD_CYCLES, 2, minimum cycles q_out stays stable after an update (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_al_in  input  1  asynchronous, active-low reset.
- req_in  input  NUM_REQ  per-requester write request, level.
- wdata_in  input  NUM_REQ*DATA_WIDTH  packed write data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt_out  output  NUM_REQ  one-hot grant, registered.
- q_out  output  DATA_WIDTH  shared register contents.
- upd_out  output  1  one-cycle pulse after q_out changes.
- busy_out  output  1  high in GNT or HOLD state.

Behaviour:
- Reset (reset_al_in=0, async, any time including mid-operation):
  - gnt_out=0, q_out=0, upd_out=0, busy_out=0.
  - State=IDLE, RR pointer=0, hold counter=0.
  - Outputs clear immediately, without waiting for clk.
  - After release, operation resumes on the first rising edge with reset_al_in=1.
- States: IDLE, GNT, HOLD. All outputs are registered.
- IDLE:
  - If req_in != 0, select the first set bit scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - Next edge: gnt_out = one-hot of winner, state → GNT.
  - If req_in == 0, stay in IDLE.
- GNT (exactly one cycle):
  - Winner w must present wdata_in while req_in[w]=1.
  - At the closing edge, if req_in[w]=1:
    - q_out <= wdata slice w; upd_out=1 for the following cycle.
    - ptr <= (w+1) mod NUM_REQ; gnt_out <= 0.
    - If HOLD_CYCLES>0: state → HOLD with counter=HOLD_CYCLES. Else: state → IDLE.
  - At the closing edge, if req_in[w]=0 (requester withdrew):
    - No write, upd_out stays 0, ptr unchanged, gnt_out <= 0, state → IDLE.
- HOLD:
  - Counter decrements each edge. gnt_out=0. Requests are ignored but not lost (level-sensitive).
  - When counter reaches 1, next edge → IDLE.
  - Grant-to-grant spacing is therefore 1 (GNT) + HOLD_CYCLES + 1 (IDLE) cycles minimum.
- Latency:
  - req_in rise in IDLE → gnt_out high after 1 edge.
  - gnt_out high → q_out updated after 1 edge.
- busy_out = (state==GNT) or (state==HOLD).
- Fairness: a requester holding req_in continuously is granted within NUM_REQ grants.
- Simultaneous requests: resolved strictly by the RR order above; no fixed priority except ptr=0 after reset.
- Requests changing while in GNT or HOLD do not affect the current grant.
- wdata_in of non-granted requesters is ignored.
- q_out changes only on a completed GNT write or on reset.

Test Plan:
1. Reset, then req_in=4'b0100 with wdata slice 2=8'hA5 → gnt_out=4'b0100 one edge later; next edge q_out=8'hA5, upd_out=1 for 1 cycle; busy_out high for 3 cycles (GNT + 2 HOLD).
2. req_in=4'b1111 held with slices 8'h10/8'h21/8'h32/8'h43 → grants in order 0,1,2,3,0; q_out sequence 10,21,32,43,10; each grant spaced 4 cycles apart.
3. After a grant to requester 3 (ptr=0), assert req_in=4'b1010 → grant to 1, then 3; ptr wrap-around verified.
4. Drop req_in[w] during GNT → q_out unchanged, upd_out=0; next grant goes to the same w if it re-requests (ptr unchanged).
5. Pull reset_al_in low mid-GNT and mid-HOLD between clock edges → gnt_out, q_out, upd_out, busy_out go to 0 immediately; after release with req_in=4'b0001, requester 0 is granted first.
6. HOLD_CYCLES=0 build with req_in=4'b0011 held → alternating grants 0,1,0 every 2 cycles; no HOLD state entered.

Source files
------------

// File: rtl/ff_reg_rr_arbiter.sv
// ff_reg_rr_arbiter: round-robin write sequencer for one shared register with post-write hold
module ff_reg_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset_al_in,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
    output logic [NUM_REQ-1:0]            gnt_out,
    output logic [DATA_WIDTH-1:0]         q_out,
    output logic                          upd_out,
    output logic                          busy_out
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] sel;
    logic [3:0]    cnt;
    logic          found;
    assign busy_out = (state == GNT) || (state == HOLD);
    // scan from ptr upward with wrap; walking offsets downward lets the nearest requester win last
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_in[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end
    // grant, write-or-abort, then hold q_out stable before re-arbitrating
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            gnt_out <= '0;
            q_out   <= '0;
            upd_out <= 1'b0;
        end else begin
            upd_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_out <= NUM_REQ'(1) << sel;
                        win     <= sel;
                        state   <= GNT;
                    end
                end
                GNT: begin
                    gnt_out <= '0;
                    if (req_in[win]) begin
                        q_out   <= wdata_in[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                        upd_out <= 1'b1;
                        ptr     <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                        if (HOLD_CYCLES > 0) begin
                            state <= HOLD;
                            cnt   <= 4'(HOLD_CYCLES);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
